// File: rtl/apb_cp_regif_pkg.sv
// Shared constants for the cipher-controller APB register interface:
// register map, buffer windows, bit positions and bus FSM encoding.
package apb_cp_regif_pkg;

  localparam logic [31:0] CTRL_OFS     = 32'h0000_0000;
  localparam logic [31:0] SIZE_OFS     = 32'h0000_0004;
  localparam logic [31:0] STATUS_OFS   = 32'h0000_0008;

  localparam logic [31:0] IN_WIN_BASE  = 32'h0000_1000;
  localparam logic [31:0] OUT_WIN_BASE = 32'h0000_2000;
  localparam logic [31:0] WIN_SIZE     = 32'h0000_0800;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IE_BIT     = 1;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam logic [11:0] MAX_BYTE_CNT = 12'd2048;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD1  = 2'd1,
    S_RD2  = 2'd2
  } busState_e;

  function automatic logic inWindow(input logic [31:0] addr, input logic [31:0] base);
    return (addr >= base) && (addr < (base + WIN_SIZE));
  endfunction

endpackage

// File: rtl/apb_cp_regif_if.sv
// APB3 bus bundle between the host master and the cipher register slave.
interface apb_cp_regif_if #(parameter int P_ADDR_W = 14);
  logic                iPsel;
  logic                iPenable;
  logic                iPwrite;
  logic [P_ADDR_W-1:0] iPaddr;
  logic [31:0]         iPwdata;
  logic [31:0]         oPrdata;
  logic                oPready;
  logic                oPslverr;

  modport master (output iPsel, iPenable, iPwrite, iPaddr, iPwdata,
                  input  oPrdata, oPready, oPslverr);
  modport slave  (input  iPsel, iPenable, iPwrite, iPaddr, iPwdata,
                  output oPrdata, oPready, oPslverr);
endinterface

// File: rtl/apb_cp_regif_addr_dec.sv
// Combinational address decoder: region hits, buffer line/lane and the
// combined error flag for the current APB access.
module apb_cp_addr_dec
  import apb_cp_regif_pkg::*;
#(
  parameter int P_ADDR_W = 14
) (
  input  logic [P_ADDR_W-1:0] addr,
  input  logic                write,
  input  logic [31:0]         wdata,
  input  logic                busy,
  input  logic                sizeZero,
  output logic                hitCtrl,
  output logic                hitSize,
  output logic                hitStatus,
  output logic                hitInWin,
  output logic                hitOutWin,
  output logic [6:0]          line,
  output logic [1:0]          lane,
  output logic                err
);

  logic [31:0] addrW_s;
  logic        unmapped_s;
  logic        sizeBad_s;
  logic        startBad_s;
  logic        winBusy_s;

  assign addrW_s   = 32'(addr) & ~32'h0000_0003;
  assign hitCtrl   = (addrW_s == CTRL_OFS);
  assign hitSize   = (addrW_s == SIZE_OFS);
  assign hitStatus = (addrW_s == STATUS_OFS);
  assign hitInWin  = inWindow(addrW_s, IN_WIN_BASE);
  assign hitOutWin = inWindow(addrW_s, OUT_WIN_BASE);
  assign line      = addr[10:4];
  assign lane      = addr[3:2];

  assign unmapped_s = ~(hitCtrl | hitSize | hitStatus | hitInWin | hitOutWin);
  // SIZE is frozen while an operation runs so the controller sees a stable count
  assign sizeBad_s  = hitSize & write & ((wdata[11:0] > MAX_BYTE_CNT) | busy);
  assign startBad_s = hitCtrl & write & wdata[CTRL_START_BIT] & (busy | sizeZero);
  assign winBusy_s  = (hitInWin | hitOutWin) & busy;

  assign err = unmapped_s | (hitInWin & ~write) | (hitOutWin & write) |
               sizeBad_s | startBad_s | winBusy_s;

endmodule

// File: rtl/apb_cp_regif.sv
// APB3 slave in front of the cipher controller: control/status registers,
// input-buffer write window and three-cycle output-buffer read window.
module apb_cp_regif
  import apb_cp_regif_pkg::*;
#(
  parameter int P_ADDR_W = 14
) (
  input  logic                iClk,
  input  logic                iRsn,
  apb_cp_regif_if.slave       bus,
  output logic                oStCp,
  output logic [11:0]         oCpByteSize,
  input  logic                iCpDone,
  output logic                oWrEn_CpInBuf,
  output logic [3:0]          oWdSel_CpInBuf,
  output logic [6:0]          oWrAddr_CpInBuf,
  output logic [127:0]        oWrDt_CpInBuf,
  output logic                oRdEn_CpOutBuf,
  output logic [6:0]          oRdAddr_CpOutBuf,
  input  logic [127:0]        iRdDt_CpOutBuf,
  output logic                oIrq
);

  busState_e   state_r, stateNext_s;
  logic [11:0] size_r;
  logic        ie_r, busy_r, done_r, stCp_r;
  logic        wrEn_r;
  logic [3:0]  wdSel_r;
  logic [6:0]  wrAddr_r;
  logic [127:0] wrDt_r;
  logic [31:0] rdData_r, regRdData_s, prdata_s;
  logic        pready_s, pslverr_s, rdEn_s;
  logic        hitCtrl_s, hitSize_s, hitStatus_s, hitInWin_s, hitOutWin_s, decErr_s;
  logic [6:0]  line_s;
  logic [1:0]  lane_s;
  logic        access_s, regWrite_s, startOk_s, bufWrite_s, doneClr_s;

  apb_cp_addr_dec #(.P_ADDR_W(P_ADDR_W)) uAddrDec (
    .addr      (bus.iPaddr),
    .write     (bus.iPwrite),
    .wdata     (bus.iPwdata),
    .busy      (busy_r),
    .sizeZero  (size_r == 12'd0),
    .hitCtrl   (hitCtrl_s),
    .hitSize   (hitSize_s),
    .hitStatus (hitStatus_s),
    .hitInWin  (hitInWin_s),
    .hitOutWin (hitOutWin_s),
    .line      (line_s),
    .lane      (lane_s),
    .err       (decErr_s)
  );

  assign access_s    = bus.iPsel & bus.iPenable;
  assign regWrite_s  = access_s & (state_r == S_IDLE) & bus.iPwrite & ~decErr_s;
  assign startOk_s   = regWrite_s & hitCtrl_s & bus.iPwdata[CTRL_START_BIT];
  assign bufWrite_s  = regWrite_s & hitInWin_s;
  assign doneClr_s   = regWrite_s & hitStatus_s & bus.iPwdata[STATUS_DONE_BIT];

  // Register read mux for the control/status space
  always_comb begin
    regRdData_s = 32'h0;
    if (hitCtrl_s) begin
      regRdData_s[CTRL_IE_BIT] = ie_r;
    end else if (hitSize_s) begin
      regRdData_s[11:0] = size_r;
    end else if (hitStatus_s) begin
      regRdData_s[STATUS_BUSY_BIT] = busy_r;
      regRdData_s[STATUS_DONE_BIT] = done_r;
    end else begin
      regRdData_s = 32'h0;
    end
  end

  // Bus FSM next state and access-phase responses
  always_comb begin
    stateNext_s = state_r;
    pready_s    = 1'b0;
    pslverr_s   = 1'b0;
    prdata_s    = 32'h0;
    rdEn_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (access_s && decErr_s) begin
          pready_s  = 1'b1;
          pslverr_s = 1'b1;
        end else if (access_s && hitOutWin_s) begin
          rdEn_s      = 1'b1;
          stateNext_s = S_RD1;
        end else if (access_s) begin
          pready_s = 1'b1;
          prdata_s = bus.iPwrite ? 32'h0 : regRdData_s;
        end else begin
          stateNext_s = S_IDLE;
        end
      end
      S_RD1: stateNext_s = S_RD2;
      S_RD2: begin
        pready_s    = 1'b1;
        prdata_s    = rdData_r;
        stateNext_s = S_IDLE;
      end
      default: stateNext_s = S_IDLE;
    endcase
  end

  // Bus FSM state register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) state_r <= S_IDLE;
    else       state_r <= stateNext_s;
  end

  // Control/status registers; a completion pulse beats a same-cycle DONE clear
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      size_r <= 12'd0;
      ie_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      stCp_r <= 1'b0;
    end else begin
      if (regWrite_s && hitSize_s) size_r <= bus.iPwdata[11:0];
      if (regWrite_s && hitCtrl_s) ie_r <= bus.iPwdata[CTRL_IE_BIT];
      if (startOk_s)    busy_r <= 1'b1;
      else if (iCpDone) busy_r <= 1'b0;
      if (iCpDone)        done_r <= 1'b1;
      else if (doneClr_s) done_r <= 1'b0;
      stCp_r <= startOk_s;
    end
  end

  // One-cycle input-buffer write strobe and payload
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      wrEn_r   <= 1'b0;
      wdSel_r  <= 4'h0;
      wrAddr_r <= 7'h0;
      wrDt_r   <= 128'h0;
    end else begin
      wrEn_r   <= bufWrite_s;
      wdSel_r  <= bufWrite_s ? (4'b0001 << lane_s) : 4'h0;
      wrAddr_r <= bufWrite_s ? line_s : 7'h0;
      wrDt_r   <= bufWrite_s ? {4{bus.iPwdata}} : 128'h0;
    end
  end

  // Output-buffer lane capture one cycle after the read strobe
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn)                 rdData_r <= 32'h0;
    else if (state_r == S_RD1) rdData_r <= iRdDt_CpOutBuf[{lane_s, 5'b00000} +: 32];
    else                       rdData_r <= rdData_r;
  end

  assign bus.oPrdata      = prdata_s;
  assign bus.oPready      = pready_s;
  assign bus.oPslverr     = pslverr_s;
  assign oStCp            = stCp_r;
  assign oCpByteSize      = size_r;
  assign oWrEn_CpInBuf    = wrEn_r;
  assign oWdSel_CpInBuf   = wdSel_r;
  assign oWrAddr_CpInBuf  = wrAddr_r;
  assign oWrDt_CpInBuf    = wrDt_r;
  assign oRdEn_CpOutBuf   = rdEn_s;
  assign oRdAddr_CpOutBuf = rdEn_s ? line_s : 7'h0;
  assign oIrq             = done_r & ie_r;

endmodule

// File: tb/tb_apb_cp_regif.sv
// Bench for apb_cp_regif: vector table, directed corner sequences and a
// randomized run against a register-level reference model.
module tb_apb_cp_regif;

  logic         iClk = 1'b0;
  logic         iRsn = 1'b0;
  logic         oStCp, oWrEn, oRdEn, oIrq, iCpDone;
  logic [11:0]  oCpByteSize;
  logic [3:0]   oWdSel;
  logic [6:0]   oWrAddr, oRdAddr;
  logic [127:0] oWrDt, iRdDt;

  apb_cp_regif_if #(.P_ADDR_W(14)) apbIf ();

  apb_cp_regif #(.P_ADDR_W(14)) dut (
    .iClk(iClk), .iRsn(iRsn), .bus(apbIf),
    .oStCp(oStCp), .oCpByteSize(oCpByteSize), .iCpDone(iCpDone),
    .oWrEn_CpInBuf(oWrEn), .oWdSel_CpInBuf(oWdSel), .oWrAddr_CpInBuf(oWrAddr),
    .oWrDt_CpInBuf(oWrDt), .oRdEn_CpOutBuf(oRdEn), .oRdAddr_CpOutBuf(oRdAddr),
    .iRdDt_CpOutBuf(iRdDt), .oIrq(oIrq)
  );

  always #5 iClk = ~iClk;

  int total = 0, bad = 0;
  int stCnt = 0, wrCnt = 0, rdCnt = 0;
  logic [6:0] rdAddrSeen = 7'h7F;

  // Pulse counters for the strobes, sampled away from the active edge
  always @(negedge iClk) begin
    if (oStCp) stCnt++;
    if (oWrEn) wrCnt++;
    if (oRdEn) begin
      rdCnt++;
      rdAddrSeen = oRdAddr;
    end
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [13:0] a, input logic [31:0] d, input logic doneHit,
                      output logic [31:0] rd, output logic err, output int nCyc);
    logic got;
    @(posedge iClk); #1;
    apbIf.iPsel = 1'b1; apbIf.iPwrite = wr; apbIf.iPaddr = a; apbIf.iPwdata = d; apbIf.iPenable = 1'b0;
    @(posedge iClk); #1;
    apbIf.iPenable = 1'b1;
    iCpDone = doneHit;
    nCyc = 0; rd = 32'h0; err = 1'b0; got = 1'b0;
    while (!got && nCyc < 8) begin
      @(negedge iClk);
      nCyc++;
      if (apbIf.oPready) begin
        got = 1'b1; rd = apbIf.oPrdata; err = apbIf.oPslverr;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL xfer-timeout addr=%0h: no oPready in %0d cycles, required within 3", a, nCyc);
    end
    @(posedge iClk); #1;
    apbIf.iPsel = 1'b0; apbIf.iPenable = 1'b0; iCpDone = 1'b0;
  endtask

  task automatic wrChk(input string nm, input logic [13:0] a, input logic [31:0] d, input logic expErr);
    logic [31:0] rd; logic err; int nc;
    xfer(1'b1, a, d, 1'b0, rd, err, nc);
    check({nm, " slverr"}, err, expErr);
    check({nm, " cycles"}, nc, 1);
  endtask

  task automatic rdChk(input string nm, input logic [13:0] a, input logic [31:0] expD, input logic expErr, input int expCyc);
    logic [31:0] rd; logic err; int nc;
    xfer(1'b0, a, 32'h0, 1'b0, rd, err, nc);
    check({nm, " slverr"}, err, expErr);
    check({nm, " rdata"}, rd, expD);
    check({nm, " cycles"}, nc, expCyc);
  endtask

  task automatic applyReset();
    #1 iRsn = 1'b0;
    apbIf.iPsel = 1'b0; apbIf.iPenable = 1'b0; apbIf.iPwrite = 1'b0;
    apbIf.iPaddr = 14'h0; apbIf.iPwdata = 32'h0; iCpDone = 1'b0;
    repeat (2) @(posedge iClk);
    #1 iRsn = 1'b1;
  endtask

  task automatic pulseDone();
    @(posedge iClk); #1 iCpDone = 1'b1;
    @(posedge iClk); #1 iCpDone = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRd;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd; logic err; int nc, s0;
    logic [13:0] unm [9];
    logic [11:0] mSize; logic mIe, mBusy, mDone;
    int expSt, expWr, expRd, w0, r0;

    vecs[0]  = '{1'b0, 14'h0004, 32'h0,    1'b0, 32'h0};
    vecs[1]  = '{1'b0, 14'h0008, 32'h0,    1'b0, 32'h0};
    vecs[2]  = '{1'b1, 14'h0004, 32'd32,   1'b0, 32'h0};
    vecs[3]  = '{1'b0, 14'h0004, 32'h0,    1'b0, 32'd32};
    vecs[4]  = '{1'b1, 14'h0004, 32'd2049, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 14'h0004, 32'h0,    1'b0, 32'd32};
    vecs[6]  = '{1'b1, 14'h0004, 32'd2048, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 14'h0004, 32'h0,    1'b0, 32'd2048};
    vecs[8]  = '{1'b1, 14'h0000, 32'h2,    1'b0, 32'h0};
    vecs[9]  = '{1'b0, 14'h0000, 32'h0,    1'b0, 32'h2};
    vecs[10] = '{1'b0, 14'h1000, 32'h0,    1'b1, 32'h0};
    vecs[11] = '{1'b1, 14'h2000, 32'h5,    1'b1, 32'h0};
    vecs[12] = '{1'b0, 14'h000C, 32'h0,    1'b1, 32'h0};
    vecs[13] = '{1'b1, 14'h3000, 32'h7,    1'b1, 32'h0};
    vecs[14] = '{1'b1, 14'h0004, 32'h0,    1'b0, 32'h0};
    vecs[15] = '{1'b1, 14'h0000, 32'h1,    1'b1, 32'h0};
    vecs[16] = '{1'b0, 14'h0008, 32'h0,    1'b0, 32'h0};
    vecs[17] = '{1'b1, 14'h0000, 32'h0,    1'b0, 32'h0};
    unm = '{14'h000C, 14'h0010, 14'h0FFC, 14'h0800, 14'h1800, 14'h1FFC, 14'h2800, 14'h3000, 14'h3FFC};
    iRdDt = 128'h0;

    applyReset();
    @(negedge iClk);
    check("reset outputs", {oStCp, oCpByteSize, oWrEn, oWdSel, oWrAddr, oRdEn, oRdAddr, oIrq,
                            apbIf.oPrdata, apbIf.oPready, apbIf.oPslverr}, 68'h0);
    check("reset wrdt", oWrDt, 128'h0);

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, rd, err, nc);
      check($sformatf("vec%0d slverr", i), err, vecs[i].expErr);
      if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].expRd);
    end
    check("table no start", stCnt, 0);

    // Buffer write strobe lands one cycle after the access
    wrChk("bufwr", 14'h1014, 32'hDEADBEEF, 1'b0);
    @(negedge iClk);
    check("bufwr strobe", {oWrEn, oWdSel, oWrAddr}, {1'b1, 4'b0010, 7'd1});
    check("bufwr data", oWrDt, {4{32'hDEADBEEF}});
    @(negedge iClk);
    check("bufwr one cycle", oWrEn, 1'b0);

    wrChk("size32", 14'h0004, 32'd32, 1'b0);
    s0 = stCnt;
    wrChk("start", 14'h0000, 32'h3, 1'b0);
    @(negedge iClk);
    check("stcp high", oStCp, 1'b1);
    @(negedge iClk);
    check("stcp low", oStCp, 1'b0);
    check("stcp count", stCnt - s0, 1);
    rdChk("busy status", 14'h0008, 32'h1, 1'b0, 1);
    check("byte size", oCpByteSize, 12'd32);
    w0 = wrCnt;
    wrChk("busy bufwr", 14'h1000, 32'h1234, 1'b1);
    wrChk("busy size", 14'h0004, 32'd64, 1'b1);
    wrChk("busy restart", 14'h0000, 32'h3, 1'b1);
    rdChk("busy outrd", 14'h2000, 32'h0, 1'b1, 1);
    @(negedge iClk);
    check("busy no wren", wrCnt - w0, 0);
    check("busy size kept", oCpByteSize, 12'd32);

    pulseDone();
    @(negedge iClk);
    check("irq set", oIrq, 1'b1);
    rdChk("done status", 14'h0008, 32'h2, 1'b0, 1);
    wrChk("done clr", 14'h0008, 32'h2, 1'b0);
    check("irq clr", oIrq, 1'b0);
    rdChk("clr status", 14'h0008, 32'h0, 1'b0, 1);

    iRdDt = 128'h44444444_33333333_22222222_11111111;
    r0 = rdCnt; rdAddrSeen = 7'h7F;
    rdChk("outrd", 14'h2008, 32'h33333333, 1'b0, 3);
    check("outrd rden", rdCnt - r0, 1);
    check("outrd addr", rdAddrSeen, 7'd0);
    rdChk("outrd line", 14'h27F4, 32'h22222222, 1'b0, 3);
    check("outrd line addr", rdAddrSeen, 7'h7F);

    // DONE set and W1C clear in the same cycle: the set wins
    wrChk("start2", 14'h0000, 32'h1, 1'b0);
    xfer(1'b1, 14'h0008, 32'h2, 1'b1, rd, err, nc);
    check("setwins slverr", err, 1'b0);
    rdChk("setwins status", 14'h0008, 32'h2, 1'b0, 1);

    wrChk("start3", 14'h0000, 32'h3, 1'b0);
    applyReset();
    rdChk("rst status", 14'h0008, 32'h0, 1'b0, 1);
    rdChk("rst size", 14'h0004, 32'h0, 1'b0, 1);
    rdChk("rst ctrl", 14'h0000, 32'h0, 1'b0, 1);
    s0 = stCnt;
    wrChk("size2049", 14'h0004, 32'd2049, 1'b1);
    wrChk("start size0", 14'h0000, 32'h1, 1'b1);
    rdChk("size stays0", 14'h0004, 32'h0, 1'b0, 1);
    @(negedge iClk);
    check("no stcp", stCnt - s0, 0);

    // Reset in the middle of an output-buffer read abandons it
    @(posedge iClk); #1;
    apbIf.iPsel = 1'b1; apbIf.iPwrite = 1'b0; apbIf.iPaddr = 14'h2004;
    @(posedge iClk); #1 apbIf.iPenable = 1'b1;
    @(negedge iClk);
    check("midrd rden", {apbIf.oPready, oRdEn}, 2'b01);
    @(posedge iClk); #1 iRsn = 1'b0;
    @(negedge iClk);
    check("midrd reset", {apbIf.oPready, oRdEn}, 2'b01);
    apbIf.iPsel = 1'b0; apbIf.iPenable = 1'b0;
    @(posedge iClk); #1 iRsn = 1'b1;
    rdChk("after midrd", 14'h2004, 32'h22222222, 1'b0, 3);

    // Randomized run against the register-level model
    applyReset();
    mSize = 12'd0; mIe = 1'b0; mBusy = 1'b0; mDone = 1'b0;
    expSt = 0; expWr = 0; expRd = 0;
    s0 = stCnt; w0 = wrCnt; r0 = rdCnt;
    for (int n = 0; n < 250; n++) begin
      int kind; logic wr; logic [13:0] a; logic [31:0] d, eRd; logic eErr; int eCyc;
      kind = $urandom_range(0, 6);
      wr = 1'($urandom_range(0, 1));
      d = $urandom();
      iRdDt = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (kind == 6) begin
        if (mBusy) begin
          pulseDone();
          mBusy = 1'b0; mDone = 1'b1;
          check($sformatf("rnd%0d irq", n), oIrq, mDone & mIe);
        end
      end else begin
        case (kind)
          0: begin a = 14'h0000; d = d & 32'h3; end
          1: begin a = 14'h0004; if ($urandom_range(0, 3) == 0) d = 32'h0; else d = 32'($urandom_range(0, 4095)); end
          2: a = 14'h0008;
          3: a = 14'h1000 + 14'($urandom_range(0, 2047));
          4: a = 14'h2000 + 14'($urandom_range(0, 2047));
          default: a = unm[$urandom_range(0, 8)];
        endcase
        if (kind < 3) a[1:0] = 2'($urandom_range(0, 3));
        eErr = (kind == 5) || (kind == 3 && !wr) || (kind == 4 && wr) || ((kind == 3 || kind == 4) && mBusy) ||
               (kind == 1 && wr && (d[11:0] > 12'd2048 || mBusy)) ||
               (kind == 0 && wr && d[0] && (mBusy || mSize == 12'd0));
        eRd = 32'h0;
        if (!eErr && !wr) begin
          if (kind == 0) eRd = {30'h0, mIe, 1'b0};
          else if (kind == 1) eRd = {20'h0, mSize};
          else if (kind == 2) eRd = {30'h0, mDone, mBusy};
          else if (kind == 4) eRd = 32'(iRdDt >> (32 * int'(a[3:2])));
        end
        eCyc = (kind == 4 && !wr && !eErr) ? 3 : 1;
        xfer(wr, a, d, 1'b0, rd, err, nc);
        check($sformatf("rnd%0d slverr a=%0h", n, a), err, eErr);
        check($sformatf("rnd%0d cycles a=%0h", n, a), nc, eCyc);
        if (!wr) check($sformatf("rnd%0d rdata a=%0h", n, a), rd, eRd);
        if (!eErr && wr) begin
          if (kind == 0) begin mIe = d[1]; if (d[0]) begin mBusy = 1'b1; expSt++; end end
          if (kind == 1) mSize = d[11:0];
          if (kind == 2 && d[1]) mDone = 1'b0;
          if (kind == 3) expWr++;
        end
        if (!eErr && !wr && kind == 4) expRd++;
        check($sformatf("rnd%0d bytesize", n), oCpByteSize, mSize);
        check($sformatf("rnd%0d irq", n), oIrq, mDone & mIe);
      end
    end
    repeat (2) @(negedge iClk);
    check("rnd starts", stCnt - s0, expSt);
    check("rnd bufwrites", wrCnt - w0, expWr);
    check("rnd bufreads", rdCnt - r0, expRd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
